// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data RAM behind a valid/ready request channel,
// answering each load/store after WAIT_STATES cycles on a valid/ready response channel.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    state_t           state_q;
    req_t             req_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [31:0]      rdata_q;
    logic             error_q;
    logic [31:0]      mem_q [DEPTH_WORDS];

    req_t             req_in_c;
    req_t             acc_c;
    logic             acc_fire_c;
    logic             acc_err_c;
    logic [IDX_W-1:0] acc_idx_c;
    logic [31:0]      acc_rdata_c;

    assign req_in_c = '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};

    // With zero wait states the access happens on the accept edge, so it must use the live request.
    always_comb begin
        acc_c       = (state_q == S_IDLE) ? req_in_c : req_q;
        acc_err_c   = (acc_c.addr[1:0] != 2'b00) || (acc_c.addr[31:2] >= DEPTH_LIM);
        acc_idx_c   = acc_c.addr[IDX_W+1:2];
        acc_fire_c  = ((state_q == S_IDLE) && req_valid && (WAIT_STATES == 0))
                   || ((state_q == S_WAIT) && (cnt_q == CNT_W'(1)));
        acc_rdata_c = (acc_c.write || acc_err_c) ? 32'd0 : mem_q[acc_idx_c];
    end

    // Array is not reset; a reset on the access edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (!reset && acc_fire_c && acc_c.write && !acc_err_c) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_c.wstrb[k]) begin
                    mem_q[acc_idx_c][8*k +: 8] <= acc_c.wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_q       <= req_in_c;
                        cnt_q       <= WAIT_INIT;
                        req_ready_q <= 1'b0;
                        if (acc_fire_c) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rdata_q     <= acc_rdata_c;
                            error_q     <= acc_err_c;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (acc_fire_c) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rdata_q     <= acc_rdata_c;
                        error_q     <= acc_err_c;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rdata_q     <= 32'd0;
                        error_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_STATES 1, 0, 3) checked against a
// word-array reference model with directed and randomized transactions.
module tb_data_mem_responder;
    localparam int DEPTH = 64;
    localparam int NDUT  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_ready = 1'b0;
    int          sel = 0;

    logic        rv  [NDUT];
    logic        rdy [NDUT];
    logic        vld [NDUT];
    logic [31:0] rd  [NDUT];
    logic        er  [NDUT];
    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;

    logic [31:0] model_mem [NDUT][DEPTH];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NDUT; i++) rv[i] = req_valid && (sel == i);
    end
    assign o_ready = rdy[sel];
    assign o_valid = vld[sel];
    assign o_rdata = rd[sel];
    assign o_err   = er[sel];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) dut_ws1 (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(vld[0]),
        .rsp_ready(rsp_ready), .rsp_rdata(rd[0]), .rsp_error(er[0]));
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(vld[1]),
        .rsp_ready(rsp_ready), .rsp_rdata(rd[1]), .rsp_error(er[1]));
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut_ws3 (
        .clk(clk), .reset(reset), .req_valid(rv[2]), .req_ready(rdy[2]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(vld[2]),
        .rsp_ready(rsp_ready), .rsp_rdata(rd[2]), .rsp_error(er[2]));

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    // Reference: byte address -> word index, range/alignment check, byte-lane merge.
    task automatic model_access(input int d, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] st,
                                output logic [31:0] exp_rd, output logic exp_err);
        int unsigned widx;
        widx    = a / 4;
        exp_err = (a % 4 != 0) || (widx >= DEPTH);
        exp_rd  = '0;
        if (exp_err) return;
        if (wr) begin
            for (int k = 0; k < 4; k++)
                if (st[k]) model_mem[d][widx][8*k +: 8] = wd[8*k +: 8];
        end else begin
            exp_rd = model_mem[d][widx];
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one transaction and reports what the DUT did; callers compare.
    task automatic run_txn(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] st, input int hold,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output logic stable, output logic released, output logic timeout);
        int n;
        @(negedge clk);
        sel = d; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = st;
        req_valid = 1'b1; rsp_ready = 1'b0;
        rdata = '0; err = 1'b0; lat = 0; stable = 1'b1; released = 1'b0; timeout = 1'b0;
        n = 0;
        while (o_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (o_ready !== 1'b1) begin timeout = 1'b1; req_valid = 1'b0; return; end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_wstrb = 4'($urandom);
        n = 0;
        do begin
            @(negedge clk); n++;
            if (o_ready !== 1'b0) stable = 1'b0;
        end while (o_valid !== 1'b1 && n < 50);
        if (o_valid !== 1'b1) begin timeout = 1'b1; return; end
        lat = n; rdata = o_rdata; err = o_err;
        repeat (hold) begin
            @(negedge clk);
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_rdata !== rdata || o_err !== err) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        released = (o_valid === 1'b0) && (o_ready === 1'b1);
    endtask

    task automatic test_reset();
        apply_reset();
        for (int d = 0; d < NDUT; d++) begin
            sel = d; #1;
            n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready dut%0d got %b want 1", d, o_ready); end
            n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid dut%0d got %b want 0", d, o_valid); end
            n_cmp++; if (o_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_rdata dut%0d got %h want 0", d, o_rdata); end
            n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_error dut%0d got %b want 0", d, o_err); end
        end
    endtask

    task automatic test_preload();
        logic [31:0] r, e_rd, wd; logic err, e_err, st, rel, to; int lat;
        for (int d = 0; d < NDUT; d++) begin
            for (int w = 0; w < DEPTH; w++) begin
                wd = $urandom;
                model_access(d, 1'b1, 32'(4*w), wd, 4'hF, e_rd, e_err);
                run_txn(d, 1'b1, 32'(4*w), wd, 4'hF, 0, r, err, lat, st, rel, to);
                n_cmp++;
                if (to || err !== 1'b0 || r !== 32'd0 || !rel) begin
                    n_bad++; $display("FAIL preload dut%0d word %0d got err=%b rdata=%h timeout=%b want err=0 rdata=0", d, w, err, r, to);
                end
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] r, e_rd; logic err, e_err, st, rel, to; int lat;
        model_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, e_rd, e_err);
        run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, r, err, lat, st, rel, to);
        n_cmp++; if (to || lat != 2) begin n_bad++; $display("FAIL store_latency got %0d (timeout=%b) want 2", lat, to); end
        n_cmp++; if (r !== 32'd0 || err !== 1'b0) begin n_bad++; $display("FAIL store_rsp got rdata=%h err=%b want 0/0", r, err); end
        model_access(0, 1'b0, 32'h10, 32'h0, 4'h0, e_rd, e_err);
        run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1, r, err, lat, st, rel, to);
        n_cmp++; if (to || r !== 32'hDEADBEEF || err !== 1'b0) begin n_bad++; $display("FAIL load_after_store got %h err=%b want deadbeef", r, err); end
        n_cmp++; if (!st || !rel) begin n_bad++; $display("FAIL load_handshake got stable=%b released=%b want 1/1", st, rel); end
    endtask

    task automatic test_partial_store();
        logic [31:0] r, e_rd; logic err, e_err, st, rel, to; int lat;
        model_access(0, 1'b1, 32'h10, 32'h11223344, 4'h5, e_rd, e_err);
        run_txn(0, 1'b1, 32'h10, 32'h11223344, 4'h5, 0, r, err, lat, st, rel, to);
        model_access(0, 1'b0, 32'h10, 32'h0, 4'h0, e_rd, e_err);
        run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, r, err, lat, st, rel, to);
        n_cmp++; if (to || r !== 32'hDE22BE44) begin n_bad++; $display("FAIL partial_store got %h want de22be44", r); end
    endtask

    task automatic test_errors();
        logic [31:0] r, e_rd, old0; logic err, e_err, st, rel, to; int lat;
        run_txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, r, err, lat, st, rel, to);
        n_cmp++; if (to || err !== 1'b1 || r !== 32'd0) begin n_bad++; $display("FAIL misaligned_load got err=%b rdata=%h want 1/0", err, r); end
        old0 = model_mem[0][0];
        run_txn(0, 1'b1, 32'(4*DEPTH), 32'hCAFEF00D, 4'hF, 0, r, err, lat, st, rel, to);
        n_cmp++; if (to || err !== 1'b1 || r !== 32'd0) begin n_bad++; $display("FAIL oob_store got err=%b rdata=%h want 1/0", err, r); end
        run_txn(0, 1'b1, 32'h8000_0000, 32'h0BADF00D, 4'hF, 0, r, err, lat, st, rel, to);
        n_cmp++; if (to || err !== 1'b1) begin n_bad++; $display("FAIL alias_store got err=%b want 1", err); end
        run_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, r, err, lat, st, rel, to);
        n_cmp++; if (to || r !== old0 || err !== 1'b0) begin n_bad++; $display("FAIL word0_unchanged got %h want %h", r, old0); end
    endtask

    task automatic test_backpressure();
        logic [31:0] a1, a2, e1, e2, cap; logic e_err, ok; int n;
        a1 = 32'(4*$urandom_range(0, DEPTH-1));
        a2 = 32'(4*$urandom_range(0, DEPTH-1));
        model_access(1, 1'b0, a1, 32'h0, 4'h0, e1, e_err);
        model_access(1, 1'b0, a2, 32'h0, 4'h0, e2, e_err);
        @(negedge clk);
        sel = 1; req_write = 1'b0; req_addr = a1; req_valid = 1'b1; rsp_ready = 1'b0;
        n = 0;
        while (o_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_addr = a2;
        @(negedge clk);
        cap = o_rdata;
        n_cmp++; if (o_valid !== 1'b1 || cap !== e1 || o_ready !== 1'b0) begin n_bad++; $display("FAIL bp_first_rsp got valid=%b rdata=%h ready=%b want 1/%h/0", o_valid, cap, o_ready, e1); end
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (o_valid !== 1'b1 || o_rdata !== cap || o_err !== 1'b0 || o_ready !== 1'b0) ok = 1'b0;
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_hold got unstable=%b want stable", !ok); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_bad++; $display("FAIL bp_after_handshake got valid=%b ready=%b want 0/1", o_valid, o_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if (o_valid !== 1'b1 || o_rdata !== e2) begin n_bad++; $display("FAIL bp_second_rsp got valid=%b rdata=%h want 1/%h", o_valid, o_rdata, e2); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_txn();
        logic [31:0] r, e_rd, old, nw; logic err, e_err, st, rel, to, quiet; int lat;
        old = model_mem[2][8];
        nw  = ~old;
        @(negedge clk);
        sel = 2; req_write = 1'b1; req_addr = 32'h20; req_wdata = nw; req_wstrb = 4'hF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (6) begin @(negedge clk); if (o_valid !== 1'b0 || o_ready !== 1'b1) quiet = 1'b0; end
        n_cmp++; if (!quiet) begin n_bad++; $display("FAIL reset_wait_no_rsp got valid=%b ready=%b want 0/1", o_valid, o_ready); end
        run_txn(2, 1'b0, 32'h20, 32'h0, 4'h0, 0, r, err, lat, st, rel, to);
        n_cmp++; if (to || r !== old) begin n_bad++; $display("FAIL reset_wait_uncommitted got %h want %h", r, old); end
        // Store reaching RESP is already committed even if reset drops the response.
        nw = $urandom;
        model_access(0, 1'b1, 32'h24, nw, 4'hF, e_rd, e_err);
        @(negedge clk);
        sel = 0; req_write = 1'b1; req_addr = 32'h24; req_wdata = nw; req_wstrb = 4'hF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_txn(0, 1'b0, 32'h24, 32'h0, 4'h0, 0, r, err, lat, st, rel, to);
        n_cmp++; if (to || r !== nw) begin n_bad++; $display("FAIL reset_resp_committed got %h want %h", r, nw); end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, r, e_rd; logic [3:0] sb; logic wr, err, e_err, st, rel, to; int lat, kind, hold;
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 40; i++) begin
                kind = $urandom_range(0, 9);
                if (kind <= 6)      a = 32'(4*$urandom_range(0, DEPTH-1));
                else if (kind == 7) a = 32'(4*$urandom_range(0, DEPTH-1) + $urandom_range(1, 3));
                else if (kind == 8) a = 32'(4*$urandom_range(DEPTH, DEPTH+8));
                else                a = (32'($urandom_range(1, 255)) << 24) | 32'(4*$urandom_range(0, DEPTH-1));
                wr = 1'($urandom); wd = $urandom; sb = 4'($urandom); hold = $urandom_range(0, 3);
                model_access(d, wr, a, wd, sb, e_rd, e_err);
                run_txn(d, wr, a, wd, sb, hold, r, err, lat, st, rel, to);
                n_cmp++;
                if (to || r !== e_rd || err !== e_err) begin
                    n_bad++; $display("FAIL rand_data dut%0d #%0d addr=%h wr=%b got rdata=%h err=%b want %h/%b", d, i, a, wr, r, err, e_rd, e_err);
                end
                n_cmp++;
                if (lat != ws_of(d) + 1 || !st || !rel) begin
                    n_bad++; $display("FAIL rand_timing dut%0d #%0d got lat=%0d stable=%b released=%b want lat=%0d", d, i, lat, st, rel, ws_of(d) + 1);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_preload();
        test_store_load();
        test_partial_store();
        test_errors();
        test_backpressure();
        test_reset_mid_txn();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
